// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Imported by the fetch interface and the fetch controller.
package fetch_pkg;

    localparam int         FETCH_ADDR_W  = 8;
    localparam int         OP_W          = 5;
    localparam logic [4:0] FETCH_HALT_OP = 5'b11111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory-side and decode-side signals of the fetch sequencer.
// master = fetch_ctrl, slave = inst_mem plus decode.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [OP_W-1:0]   mem_opcode;
    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] issue_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_addr,
        output mem_rd,
        output inst_valid,
        output issue_pc,
        input  mem_opcode,
        input  inst_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  inst_valid,
        input  issue_pc,
        output mem_opcode,
        output inst_ready,
        output redirect,
        output redirect_pc
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads inst_mem and
// hands each instruction to decode over a valid/ready handshake.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0] HALT_OP  = FETCH_HALT_OP,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    fetch_ctrl_if.master     bus,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    fetch_state_e      state;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            issued_cnt <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            issued_cnt <= cnt_d;
        end
    end

    // A redirect in ISSUE discards the held instruction.
    assign accept = bus.inst_valid & bus.inst_ready
                  & ~bus.redirect;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = issued_cnt;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_d = REQ;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = REQ;
                end else if (accept) begin
                    cnt_d = issued_cnt + CNT_ONE;
                    if (bus.mem_opcode == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc + PC_ONE;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr   = pc;
    assign bus.issue_pc   = pc;
    assign bus.mem_rd     = (state == REQ);
    assign bus.inst_valid = (state == ISSUE);
    assign halted         = (state == HALT);
    assign busy           = (state == REQ)
                          | (state == ISSUE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a registered ROM and
// a cycle-level reference model of the fetch sequence.
module tb_fetch_ctrl;

    localparam logic [4:0] HOP = 5'b11111;

    logic        clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        halted;
    logic        busy;
    logic [15:0] issued_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl_if #(.ADDR_W(8)) bus ();

    fetch_ctrl #(
        .ADDR_W  (8),
        .RESET_PC(8'h00),
        .HALT_OP (HOP),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .bus       (bus),
        .halted    (halted),
        .busy      (busy),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    // inst_mem stand-in: one registered cycle of latency
    logic [4:0] rom [256];
    logic [4:0] rom_q;

    always @(posedge clk or posedge Reset) begin
        if (Reset) rom_q <= '0;
        else if (bus.mem_rd) rom_q <= rom[bus.mem_addr];
    end
    assign bus.mem_opcode = rom_q;

    // Reference: phase 0 idle, 1 fetching, 2 offering, 3 stopped
    int         ph;
    logic [7:0] m_pc;
    logic [15:0] m_cnt;
    logic [7:0] m_acc [$];
    logic [7:0] o_acc [$];

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ph    <= 0;
            m_pc  <= 8'h00;
            m_cnt <= 16'd0;
        end else if (ph == 0 || ph == 3) begin
            if (start) begin
                ph    <= 1;
                m_pc  <= 8'h00;
                m_cnt <= 16'd0;
            end
        end else if (ph == 1) begin
            if (bus.redirect) m_pc <= bus.redirect_pc;
            else ph <= 2;
        end else if (bus.redirect) begin
            m_pc <= bus.redirect_pc;
            ph   <= 1;
        end else if (bus.inst_ready) begin
            m_acc.push_back(m_pc);
            m_cnt <= m_cnt + 16'd1;
            if (rom[m_pc] == HOP) begin
                ph <= 3;
            end else begin
                m_pc <= m_pc + 8'd1;
                ph   <= 1;
            end
        end
    end

    function automatic logic [4:0] non_halt();
        return 5'($urandom_range(0, 30));
    endfunction

    task automatic restart();
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.mem_rd !== 1'b0 || bus.inst_valid !== 1'b0 ||
            halted !== 1'b0 || busy !== 1'b0 ||
            bus.mem_addr !== 8'h00 || bus.issue_pc !== 8'h00 ||
            issued_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset: rd=%b v=%b h=%b b=%b a=%h p=%h c=%0d, want 0s",
                     bus.mem_rd, bus.inst_valid, halted, busy,
                     bus.mem_addr, bus.issue_pc, issued_cnt);
        end
        Reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_hold: busy=%b rd=%b, want 0 0",
                     busy, bus.mem_rd);
        end
    endtask

    task automatic test_program();
        logic exp_rd;
        for (int i = 0; i < 3; i++) rom[i] = non_halt();
        rom[3] = HOP;
        bus.inst_ready = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            exp_rd = (i % 2 == 1) && (i <= 7);
            n_checks++;
            if (bus.mem_rd !== exp_rd ||
                (exp_rd && bus.mem_addr !== 8'((i - 1) / 2))) begin
                n_errors++;
                $display("FAIL prog_req c%0d: rd=%b a=%h, want rd=%b a=%h",
                         i, bus.mem_rd, bus.mem_addr, exp_rd,
                         8'((i - 1) / 2));
            end
        end
        n_checks++;
        if (halted !== 1'b1 || issued_cnt !== 16'd4 ||
            bus.issue_pc !== 8'h03 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL prog_halt: h=%b c=%0d p=%h b=%b, want 1 4 03 0",
                     halted, issued_cnt, bus.issue_pc, busy);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) rom[i] = non_halt();
        bus.inst_ready = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.inst_valid !== 1'b1 || bus.mem_rd !== 1'b0 ||
                bus.issue_pc !== 8'h02 || issued_cnt !== 16'd2) begin
                n_errors++;
                $display("FAIL bp_hold k%0d: v=%b rd=%b p=%h c=%0d, want 1 0 02 2",
                         k, bus.inst_valid, bus.mem_rd, bus.issue_pc,
                         issued_cnt);
            end
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h03 ||
            bus.inst_valid !== 1'b0 || issued_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL bp_release: rd=%b a=%h v=%b c=%0d, want 1 03 0 3",
                     bus.mem_rd, bus.mem_addr, bus.inst_valid, issued_cnt);
        end
    endtask

    task automatic test_redirect_req();
        bus.inst_ready = 1'b0;
        rom[8'h10] = non_halt();
        restart();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h10;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h10 ||
            bus.inst_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL redir_req: rd=%b a=%h v=%b b=%b, want 1 10 0 1",
                     bus.mem_rd, bus.mem_addr, bus.inst_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.issue_pc !== 8'h10 ||
            bus.mem_opcode !== rom[8'h10]) begin
            n_errors++;
            $display("FAIL redir_req_issue: v=%b p=%h op=%h, want 1 10 %h",
                     bus.inst_valid, bus.issue_pc, bus.mem_opcode,
                     rom[8'h10]);
        end
    endtask

    task automatic test_redirect_issue();
        for (int i = 0; i < 6; i++) rom[i] = non_halt();
        rom[8'h40] = non_halt();
        rom[8'hFF] = non_halt();
        bus.inst_ready = 1'b1;
        restart();
        repeat (11) @(negedge clk);
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.issue_pc !== 8'h05 ||
            issued_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL redir_setup: v=%b p=%h c=%0d, want 1 05 5",
                     bus.inst_valid, bus.issue_pc, issued_cnt);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h40 ||
            bus.inst_valid !== 1'b0 || issued_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL redir_issue: rd=%b a=%h v=%b c=%0d, want 1 40 0 5",
                     bus.mem_rd, bus.mem_addr, bus.inst_valid, issued_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.issue_pc !== 8'h40 ||
            issued_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL redir_target: v=%b p=%h c=%0d, want 1 40 5",
                     bus.inst_valid, bus.issue_pc, issued_cnt);
        end
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFF;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.issue_pc !== 8'hFF) begin
            n_errors++;
            $display("FAIL wrap_issue: v=%b p=%h, want 1 ff",
                     bus.inst_valid, bus.issue_pc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00 ||
            issued_cnt !== 16'd6) begin
            n_errors++;
            $display("FAIL wrap: rd=%b a=%h c=%0d, want 1 00 6",
                     bus.mem_rd, bus.mem_addr, issued_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) rom[i] = non_halt();
        bus.inst_ready = 1'b1;
        restart();
        repeat (5) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_rd !== 1'b0 || bus.inst_valid !== 1'b0 ||
            halted !== 1'b0 || busy !== 1'b0 ||
            bus.mem_addr !== 8'h00 || bus.issue_pc !== 8'h00 ||
            issued_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: rd=%b v=%b h=%b b=%b a=%h p=%h c=%0d, want 0s",
                     bus.mem_rd, bus.inst_valid, halted, busy,
                     bus.mem_addr, bus.issue_pc, issued_cnt);
        end
        @(negedge clk);
        Reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00 ||
            issued_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_restart: rd=%b a=%h c=%0d, want 1 00 0",
                     bus.mem_rd, bus.mem_addr, issued_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? HOP : non_halt();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        m_acc.delete();
        o_acc.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.mem_rd !== (ph == 1) ||
                bus.inst_valid !== (ph == 2) ||
                halted !== (ph == 3) ||
                busy !== (ph == 1 || ph == 2) ||
                bus.mem_addr !== m_pc || bus.issue_pc !== m_pc ||
                issued_cnt !== m_cnt) begin
                n_errors++;
                $display("FAIL rand c%0d: rd=%b v=%b h=%b b=%b a=%h c=%0d, model ph=%0d pc=%h c=%0d",
                         c, bus.mem_rd, bus.inst_valid, halted, busy,
                         bus.mem_addr, issued_cnt, ph, m_pc, m_cnt);
            end
            start           = ($urandom_range(0, 7) == 0);
            bus.inst_ready  = $urandom_range(0, 2) != 0;
            bus.redirect    = ($urandom_range(0, 5) == 0);
            bus.redirect_pc = 8'($urandom);
            if (bus.inst_valid && bus.inst_ready && !bus.redirect)
                o_acc.push_back(bus.issue_pc);
        end
        start        = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_acc.size() != m_acc.size() || o_acc != m_acc) begin
            n_errors++;
            $display("FAIL rand_stream: %0d accepts seen, want %0d in model order",
                     o_acc.size(), m_acc.size());
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_backpressure();
        test_redirect_req();
        test_redirect_issue();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
